// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: the ID/EX payload layout, its flush kill mask,
// and the occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

    // ID/EX payload, MSB first; 144 bits in total.
    typedef struct packed {
        logic [5:0]  opcode;
        logic        alu_src;
        logic        wr_en_reg;
        logic [4:0]  wr_num;
        logic        dm_rw;
        logic [1:0]  dm_access_sz;
        logic [31:0] rd0_data;
        logic [31:0] rd1_data;
        logic [15:0] imm;
        logic [4:0]  shift_amount;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [31:0] pc;
    } id_ex_payload_t;

    localparam int unsigned ID_EX_WIDTH = $bits(id_ex_payload_t);

    // Bit positions of the kill bits, derived from the field widths above.
    localparam int unsigned ID_EX_WR_EN_BIT = ID_EX_WIDTH - 6 - 1 - 1;
    localparam int unsigned ID_EX_DM_RW_BIT = ID_EX_WR_EN_BIT - 5 - 1;

    // Bits cleared in out_data on flush: register write-enable and memory rw.
    localparam logic [ID_EX_WIDTH-1:0] ID_EX_CTRL_MASK =
        (ID_EX_WIDTH'(1) << ID_EX_WR_EN_BIT) | (ID_EX_WIDTH'(1) << ID_EX_DM_RW_BIT);

    localparam int unsigned OCC_W = 2;

    // Number of entries held by a stage register.
    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register placed at each stage boundary.
// Supports backpressure, flush (kills held entries and clears CTRL_MASK bits)
// and bubble insertion.
// Build option PIPE_STAGE_SKID_EN: adds a second (skid) entry so in_ready can
// be registered; without it in_ready is combinational from out_ready and the
// stage holds at most one entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = ID_EX_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CTRL_MASK = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    occ_e             state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_xfer;
    logic             out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
`else
    logic             ready_en_q;
`endif

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid_q & out_ready;

    // Next occupancy and payload moves; flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    data_d  = in_data;
                end
            end
            ONE: begin
                if (in_xfer) begin
                    if (out_xfer) begin
                        data_d = in_data;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end
`endif
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                    data_d  = skid_q;
                end
            end
`endif
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d = EMPTY;
            data_d  = data_q & ~CTRL_MASK;
        end

        out_valid_d = (state_d != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        in_ready_d  = (state_d != TWO);
`endif
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            data_q      <= RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b0;
`else
            ready_en_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
`else
            ready_en_q  <= 1'b1;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = in_ready_q;
`else
    // Combinational ready chain, held low until the first edge out of reset.
    assign in_ready = ready_en_q & (~out_valid_q | out_ready);
`endif

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign occupancy = OCC_W'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (ID/EX configuration).
// Works for both builds; PIPE_STAGE_SKID_EN selects the expected ready/occupancy rules.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned     W     = ID_EX_WIDTH;
    localparam logic [W-1:0]    RST_V = {9{16'hC3A5}};
    localparam logic [W-1:0]    MASK  = ID_EX_CTRL_MASK;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned     MAX_OCC = 2;
`else
    localparam int unsigned     MAX_OCC = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH    (W),
        .RESET_VAL(RST_V),
        .CTRL_MASK(MASK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    // Scoreboard: entries accepted but not yet delivered, oldest first.
    logic [W-1:0] sb_q[$];
    logic [W-1:0] last_out;
    logic         ready_en;
    int           n_vec;
    int           n_fail;
    logic [W-1:0] got[$];

    typedef struct {
        logic       iv;
        logic [7:0] k;
        logic       ordy;
        logic       exp_ov;
        logic [7:0] exp_k;
        logic [1:0] exp_occ;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [W-1:0] mk(input logic [7:0] k);
        return {18{k}};
    endfunction

    task automatic chk_d(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, clock, update model.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input logic rst,
                        output logic in_x, output logic out_x, output logic [W-1:0] front);
        logic exp_ir;
        int   sz;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rst;
        #1;
        sz     = sb_q.size();
        exp_ir = ready_en && ((MAX_OCC == 2) ? (sz < 2) : (sz == 0 || ordy));
        chk_i("in_ready", 32'(in_ready), 32'(exp_ir));
        chk_i("out_valid", 32'(out_valid), 32'(sz > 0));
        chk_i("occupancy", 32'(occupancy), 32'(sz));
        chk_d("out_data", out_data, last_out);
        in_x  = iv && exp_ir && rst && !fl;
        out_x = (sz > 0) && ordy && rst && !fl;
        front = (sz > 0) ? sb_q[0] : last_out;
        @(posedge clk);
        if (!rst) begin
            sb_q.delete();
            last_out = RST_V;
            ready_en = 1'b0;
        end else if (fl) begin
            sb_q.delete();
            last_out = last_out & ~MASK;
            ready_en = 1'b1;
        end else begin
            if (out_x) void'(sb_q.pop_front());
            if (in_x) sb_q.push_back(d);
            if (sb_q.size() > 0) last_out = sb_q[0];
            ready_en = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic         ix;
        logic         ox;
        logic [W-1:0] fr;
        int           idx;
        int           aa_seen;

        n_vec  = 0;
        n_fail = 0;
        sb_q.delete();
        last_out  = RST_V;
        ready_en  = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Streaming table: one accept and one delivery per cycle, then drain.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 8'(i + 1), 1'b1, 1'b1, 8'(i + 1), 2'd1};
        end
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 2'd0};

        @(posedge clk);
        @(negedge clk);

        // Reset held; offered data must not be taken.
        for (int i = 0; i < 3; i++) step(1'b1, mk(8'h55), 1'b1, 1'b0, 1'b0, ix, ox, fr);
        // First cycle after release: in_ready still low.
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, ix, ox, fr);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].iv, mk(tbl[i].k), tbl[i].ordy, 1'b0, 1'b1, ix, ox, fr);
            chk_i("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
            chk_d("tbl_out_data", out_data, mk(tbl[i].exp_k));
            chk_i("tbl_occupancy", 32'(occupancy), 32'(tbl[i].exp_occ));
        end

        // Stall: out_ready low for three cycles, then released.
        idx = 1;
        got.delete();
        for (int c = 0; c < 30 && (idx <= 4 || sb_q.size() > 0); c++) begin
            step(idx <= 4, mk(8'(idx)), c >= 3, 1'b0, 1'b1, ix, ox, fr);
            if (ix) idx++;
            if (ox) got.push_back(fr);
            if (c == 2) begin
                chk_i("stall_occupancy", 32'(occupancy), 32'(MAX_OCC));
                chk_i("stall_in_ready", 32'(in_ready), 32'(0));
                chk_d("stall_hold", out_data, mk(8'h01));
            end
        end
        chk_i("stall_count", 32'(got.size()), 32'(4));
        for (int j = 0; j < 4; j++) begin
            if (j < got.size()) chk_d("stall_order", got[j], mk(8'(j + 1)));
        end

        // Flush while full, with a simultaneous input offer.
        step(1'b1, mk(8'hFF), 1'b0, 1'b0, 1'b1, ix, ox, fr);
        step(1'b1, mk(8'hEE), 1'b0, 1'b0, 1'b1, ix, ox, fr);
        step(1'b1, mk(8'hAA), 1'b1, 1'b1, 1'b1, ix, ox, fr);
        chk_i("flush_out_valid", 32'(out_valid), 32'(0));
        chk_i("flush_occupancy", 32'(occupancy), 32'(0));
        chk_i("flush_ctrl_bits", 32'(|(out_data & MASK)), 32'(0));
        chk_d("flush_data", out_data, mk(8'hFF) & ~MASK);
        aa_seen = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b1, ix, ox, fr);
            if (out_valid && (out_data == mk(8'hAA) || out_data == mk(8'hEE))) aa_seen++;
        end
        step(1'b1, mk(8'h03), 1'b1, 1'b0, 1'b1, ix, ox, fr);
        chk_d("post_flush_data", out_data, mk(8'h03));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, ix, ox, fr);
        chk_i("flush_dropped", 32'(aa_seen), 32'(0));

        // Flush and reset together: reset wins.
        step(1'b1, mk(8'h77), 1'b0, 1'b0, 1'b1, ix, ox, fr);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, ix, ox, fr);
        chk_d("flush_rst_data", out_data, RST_V);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, ix, ox, fr);

        // Toggling out_ready every cycle.
        idx = 1;
        got.delete();
        for (int c = 0; c < 60 && (idx <= 8 || sb_q.size() > 0); c++) begin
            step(idx <= 8, mk(8'(idx)), c[0], 1'b0, 1'b1, ix, ox, fr);
            chk_i("toggle_occ_max", 32'(32'(occupancy) <= MAX_OCC), 32'(1));
            if (ix) idx++;
            if (ox) got.push_back(fr);
        end
        chk_i("toggle_count", 32'(got.size()), 32'(8));
        for (int j = 0; j < 8; j++) begin
            if (j < got.size()) chk_d("toggle_order", got[j], mk(8'(j + 1)));
        end

        // Random traffic with occasional flushes.
        for (int c = 0; c < 80; c++) begin
            step(1'($urandom_range(0, 1)), mk(8'($urandom)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'b1, ix, ox, fr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
